// File: rtl/accel_poll_sequencer_pkg.sv
// Shared types and tables for the G-sensor poll sequencer.
// Contents: sequencer state enum, sensor register addresses, configuration
// write table (register/data pairs) and the six-register read table.
package accel_pkg;

    typedef enum logic [2:0] {
        CFG_ISSUE,
        CFG_WAIT,
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        PUBLISH
    } seq_state_e;

    localparam int unsigned NUM_CFG = 3;
    localparam int unsigned NUM_RD  = 6;

    localparam logic [7:0] REG_BW_RATE     = 8'h2C;
    localparam logic [7:0] REG_POWER_CTL   = 8'h2D;
    localparam logic [7:0] REG_DATA_FORMAT = 8'h31;
    localparam logic [7:0] REG_DATAX0      = 8'h32;

    // Full resolution +/-16 g, 100 Hz output rate, then enter measure mode.
    localparam logic [7:0] CFG_REG  [NUM_CFG] = '{REG_DATA_FORMAT, REG_BW_RATE, REG_POWER_CTL};
    localparam logic [7:0] CFG_DATA [NUM_CFG] = '{8'h0B, 8'h0A, 8'h08};

    // X0, X1, Y0, Y1, Z0, Z1 are consecutive registers.
    localparam logic [7:0] RD_REG [NUM_RD] = '{
        REG_DATAX0,        REG_DATAX0 + 8'd1, REG_DATAX0 + 8'd2,
        REG_DATAX0 + 8'd3, REG_DATAX0 + 8'd4, REG_DATAX0 + 8'd5
    };

endpackage

// File: rtl/accel_poll_sequencer_if.sv
// Command interface between the poll sequencer (master) and the i2c_controller
// (slave).
//   i2c_ready          controller can accept a command
//   i2c_comms_finished one-cycle completion pulse
//   i2c_read_data      read byte, valid with i2c_comms_finished
//   start_i2c_comms    one-cycle command strobe
//   dev_addr           7-bit device address
//   reg_addr/r_w/write_data  command payload, held from strobe until finished
interface accel_poll_sequencer_if;
    logic       i2c_ready;
    logic       i2c_comms_finished;
    logic [7:0] i2c_read_data;
    logic       start_i2c_comms;
    logic [6:0] dev_addr;
    logic [7:0] reg_addr;
    logic       r_w;
    logic [7:0] write_data;

    modport master (
        input  i2c_ready, i2c_comms_finished, i2c_read_data,
        output start_i2c_comms, dev_addr, reg_addr, r_w, write_data
    );

    modport slave (
        output i2c_ready, i2c_comms_finished, i2c_read_data,
        input  start_i2c_comms, dev_addr, reg_addr, r_w, write_data
    );
endinterface

// File: rtl/accel_poll_sequencer_sample_tick_gen.sv
// Free-running sample-rate divider.
//   clk, rst  clock, synchronous active-high reset
//   enable    counter runs while high, held at zero while low
//   tick      one-cycle pulse every PERIOD cycles; first pulse PERIOD cycles
//             after enable rises
module sample_tick_gen #(
    parameter int unsigned PERIOD = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);
    localparam int unsigned   CW   = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q;
    logic          tick_q;

    // Wrap counter; the tick is registered off the wrap.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else if (cnt_q == LAST) begin
            cnt_q  <= '0;
            tick_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_q + CW'(1);
            tick_q <= 1'b0;
        end
    end

    assign tick = tick_q;
endmodule

// File: rtl/accel_poll_sequencer.sv
// Configures the G-sensor through the i2c_controller, then polls its six
// data registers at SAMPLE_RATE_HZ and publishes signed X/Y/Z samples.
//   clk, rst        clock, synchronous active-high reset
//   i2c             master side of the i2c_controller command interface
//   accel_x/y/z     signed samples {DATAn1, DATAn0}
//   sample_valid    one-cycle pulse, all axes updated together
//   cfg_done        configuration table completed
//   busy            transaction outstanding (strobe through finished)
//   timeout_err     one-cycle pulse on transaction timeout
//   sample_overrun  one-cycle pulse when a tick hits an already pending tick
module accel_poll_sequencer
    import accel_pkg::*;
#(
    parameter int unsigned SYS_CLK_SPEED  = 50000000,
    parameter int unsigned SAMPLE_RATE_HZ = 100,
    parameter logic [6:0]  DEV_ADDR       = 7'h1D,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic                   clk,
    input  logic                   rst,
    accel_poll_sequencer_if.master i2c,
    output logic [15:0]            accel_x,
    output logic [15:0]            accel_y,
    output logic [15:0]            accel_z,
    output logic                   sample_valid,
    output logic                   cfg_done,
    output logic                   busy,
    output logic                   timeout_err,
    output logic                   sample_overrun
);
    localparam int unsigned PERIOD = SYS_CLK_SPEED / SAMPLE_RATE_HZ;
    localparam int unsigned TW     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    seq_state_e       state_q;
    logic [2:0]       idx_q;
    logic [5:0][7:0]  rd_buf_q;
    logic [TW-1:0]    wait_cnt_q;
    logic             pending_q;
    logic             cfg_done_q;
    logic             sample_valid_q;
    logic             timeout_q;
    logic             overrun_q;
    logic [15:0]      accel_x_q, accel_y_q, accel_z_q;
    logic [7:0]       reg_addr_q, wdata_q;
    logic             r_w_q;

    logic             tick;
    logic             issue_c, wait_c, start_c, consume_c, timeout_hit_c;
    logic [7:0]       cmd_addr_c, cmd_wdata_c;

    sample_tick_gen #(.PERIOD(PERIOD)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .enable (cfg_done_q),
        .tick   (tick)
    );

    // Command decode; the strobe must fire in the first ISSUE cycle with ready.
    always_comb begin
        issue_c       = (state_q == CFG_ISSUE) || (state_q == RD_ISSUE);
        wait_c        = (state_q == CFG_WAIT)  || (state_q == RD_WAIT);
        start_c       = issue_c && i2c.i2c_ready && !rst;
        consume_c     = (state_q == IDLE) && pending_q;
        timeout_hit_c = wait_c && !i2c.i2c_comms_finished &&
                        (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1));
        cmd_addr_c    = RD_REG[idx_q];
        cmd_wdata_c   = 8'h00;
        if (state_q == CFG_ISSUE) begin
            cmd_addr_c  = CFG_REG[idx_q[1:0]];
            cmd_wdata_c = CFG_DATA[idx_q[1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= CFG_ISSUE;
            idx_q          <= '0;
            rd_buf_q       <= '0;
            wait_cnt_q     <= '0;
            pending_q      <= 1'b0;
            cfg_done_q     <= 1'b0;
            sample_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
            overrun_q      <= 1'b0;
            accel_x_q      <= '0;
            accel_y_q      <= '0;
            accel_z_q      <= '0;
            reg_addr_q     <= '0;
            wdata_q        <= '0;
            r_w_q          <= 1'b0;
        end else begin
            sample_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
            overrun_q      <= 1'b0;

            // One-deep tick queue; a tick coinciding with consumption re-arms it.
            if (consume_c) begin
                pending_q <= tick;
            end else if (tick) begin
                if (pending_q) begin
                    overrun_q <= 1'b1;
                end else begin
                    pending_q <= 1'b1;
                end
            end

            // Payload is captured on the strobe and held through the wait.
            if (start_c) begin
                reg_addr_q <= cmd_addr_c;
                wdata_q    <= cmd_wdata_c;
                r_w_q      <= (state_q == RD_ISSUE);
                wait_cnt_q <= '0;
            end else if (wait_c) begin
                wait_cnt_q <= wait_cnt_q + TW'(1);
            end

            case (state_q)
                CFG_ISSUE: if (start_c) state_q <= CFG_WAIT;
                CFG_WAIT: begin
                    if (i2c.i2c_comms_finished) begin
                        if (idx_q == 3'(NUM_CFG - 1)) begin
                            cfg_done_q <= 1'b1;
                            idx_q      <= '0;
                            state_q    <= IDLE;
                        end else begin
                            idx_q   <= idx_q + 3'd1;
                            state_q <= CFG_ISSUE;
                        end
                    end
                end
                IDLE: begin
                    if (pending_q) begin
                        idx_q   <= '0;
                        state_q <= RD_ISSUE;
                    end
                end
                RD_ISSUE: if (start_c) state_q <= RD_WAIT;
                RD_WAIT: begin
                    if (i2c.i2c_comms_finished) begin
                        rd_buf_q[idx_q] <= i2c.i2c_read_data;
                        if (idx_q == 3'(NUM_RD - 1)) begin
                            state_q <= PUBLISH;
                        end else begin
                            idx_q   <= idx_q + 3'd1;
                            state_q <= RD_ISSUE;
                        end
                    end
                end
                PUBLISH: begin
                    accel_x_q      <= {rd_buf_q[1], rd_buf_q[0]};
                    accel_y_q      <= {rd_buf_q[3], rd_buf_q[2]};
                    accel_z_q      <= {rd_buf_q[5], rd_buf_q[4]};
                    sample_valid_q <= 1'b1;
                    idx_q          <= '0;
                    state_q        <= IDLE;
                end
                default: state_q <= CFG_ISSUE;
            endcase

            // Abort restarts from configuration; published axes are kept.
            if (timeout_hit_c) begin
                timeout_q  <= 1'b1;
                cfg_done_q <= 1'b0;
                pending_q  <= 1'b0;
                idx_q      <= '0;
                state_q    <= CFG_ISSUE;
            end
        end
    end

    assign i2c.start_i2c_comms = start_c;
    assign i2c.dev_addr        = DEV_ADDR;
    assign i2c.reg_addr        = start_c ? cmd_addr_c : reg_addr_q;
    assign i2c.write_data      = start_c ? cmd_wdata_c : wdata_q;
    assign i2c.r_w             = start_c ? (state_q == RD_ISSUE) : r_w_q;

    assign accel_x        = accel_x_q;
    assign accel_y        = accel_y_q;
    assign accel_z        = accel_z_q;
    assign sample_valid   = sample_valid_q;
    assign cfg_done       = cfg_done_q;
    assign busy           = start_c || wait_c;
    assign timeout_err    = timeout_q;
    assign sample_overrun = overrun_q;
endmodule

// File: tb/tb_accel_poll_sequencer.sv
// Directed bench for accel_poll_sequencer with a behavioural i2c_controller.
module tb_accel_poll_sequencer;
    typedef struct {
        int         cyc;
        logic [7:0] addr;
        logic       rw;
        logic [7:0] wd;
    } strobe_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    accel_poll_sequencer_if i2c ();
    logic [15:0] accel_x, accel_y, accel_z;
    logic        sample_valid, cfg_done, busy, timeout_err, sample_overrun;

    int total = 0;
    int bad   = 0;

    // Controller model state and controls
    int         cyc = 0;
    int         lat = 20;
    int         no_finish = -1;
    bit         hold_ready = 1'b1;
    bit         m_start = 1'b0;
    bit         m_busy = 1'b0;
    int         m_cnt = 0;
    logic [7:0] m_addr = 8'h00;
    logic       m_rw = 1'b0;
    logic [7:0] m_wd = 8'h00;
    logic [7:0] mem [256];

    // Monitor logs
    strobe_t strobes[$];
    int      rdy_err = 0, stab_err = 0;
    int      sv_cnt = 0, last_sv_cyc = -1;
    int      ovr_cnt = 0, to_cnt = 0, last_to_cyc = -1;
    int      last_fin_cyc = -1, cfg_rise_cyc = -1;
    logic    cfg_prev = 1'b0;

    always #5 clk = ~clk;

    accel_poll_sequencer #(
        .SYS_CLK_SPEED  (1000),
        .SAMPLE_RATE_HZ (10),
        .DEV_ADDR       (7'h1D),
        .TIMEOUT_CYCLES (500)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i2c            (i2c),
        .accel_x        (accel_x),
        .accel_y        (accel_y),
        .accel_z        (accel_z),
        .sample_valid   (sample_valid),
        .cfg_done       (cfg_done),
        .busy           (busy),
        .timeout_err    (timeout_err),
        .sample_overrun (sample_overrun)
    );

    // Controller driver: finished arrives lat cycles after the strobe cycle.
    initial begin
        i2c.i2c_ready          = 1'b0;
        i2c.i2c_comms_finished = 1'b0;
        i2c.i2c_read_data      = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            i2c.i2c_comms_finished = 1'b0;
            if (rst) begin
                m_busy        = 1'b0;
                m_start       = 1'b0;
                i2c.i2c_ready = !hold_ready;
            end else if (m_start) begin
                m_start = 1'b0;
                if (int'(m_addr) == no_finish) begin
                    i2c.i2c_ready = !hold_ready;
                end else begin
                    m_busy        = 1'b1;
                    m_cnt         = lat - 1;
                    i2c.i2c_ready = 1'b0;
                end
            end else if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    i2c.i2c_comms_finished = 1'b1;
                    i2c.i2c_read_data      = mem[m_addr];
                    m_busy                 = 1'b0;
                    last_fin_cyc           = cyc;
                    i2c.i2c_ready          = !hold_ready;
                end
            end else begin
                i2c.i2c_ready = !hold_ready;
            end
        end
    end

    // Mid-cycle monitor of strobes and status pulses.
    initial begin
        strobe_t rec;
        forever begin
            @(negedge clk);
            if (i2c.start_i2c_comms === 1'b1) begin
                if (i2c.i2c_ready !== 1'b1) rdy_err++;
                rec.cyc  = cyc;
                rec.addr = i2c.reg_addr;
                rec.rw   = i2c.r_w;
                rec.wd   = i2c.write_data;
                strobes.push_back(rec);
                m_start = 1'b1;
                m_addr  = i2c.reg_addr;
                m_rw    = i2c.r_w;
                m_wd    = i2c.write_data;
            end
            if (m_busy && ({i2c.reg_addr, i2c.r_w, i2c.write_data} !== {m_addr, m_rw, m_wd}))
                stab_err++;
            if (sample_valid === 1'b1) begin
                sv_cnt++;
                last_sv_cyc = cyc;
            end
            if (sample_overrun === 1'b1) ovr_cnt++;
            if (timeout_err === 1'b1) begin
                to_cnt++;
                last_to_cyc = cyc;
            end
            if (cfg_done === 1'b1 && cfg_prev !== 1'b1) cfg_rise_cyc = cyc;
            cfg_prev = cfg_done;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic wait_strobes(input int n, input int budget, output bit ok);
        int k = 0;
        while (strobes.size() < n && k < budget) begin
            step(1);
            k++;
        end
        ok = (strobes.size() >= n);
    endtask

    task automatic find_strobe(input logic [7:0] a, input int from, input int budget, output int idx);
        int k = 0;
        idx = -1;
        while (idx < 0 && k <= budget) begin
            for (int j = from; j < strobes.size(); j++)
                if (idx < 0 && strobes[j].addr == a) idx = j;
            if (idx < 0) begin
                step(1);
                k++;
            end
        end
    endtask

    task automatic wait_sv(input int n, input int budget, output bit ok);
        int k = 0;
        while (sv_cnt < n && k < budget) begin
            step(1);
            k++;
        end
        ok = (sv_cnt >= n);
    endtask

    task automatic wait_cfg(input int budget, output bit ok);
        int k = 0;
        while (cfg_done !== 1'b1 && k < budget) begin
            step(1);
            k++;
        end
        ok = (cfg_done === 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        hold_ready = 1'b1;
        step(5);
        total++;
        if ({accel_x, accel_y, accel_z} !== 48'h0) begin
            bad++;
            $display("FAIL reset_axes: got %h expected 0", {accel_x, accel_y, accel_z});
        end
        total++;
        if ({sample_valid, cfg_done, busy, timeout_err, sample_overrun, i2c.start_i2c_comms} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {sample_valid, cfg_done, busy, timeout_err, sample_overrun, i2c.start_i2c_comms});
        end
        total++;
        if ({i2c.reg_addr, i2c.r_w, i2c.write_data} !== 17'h0) begin
            bad++;
            $display("FAIL reset_cmd: got %h expected 0", {i2c.reg_addr, i2c.r_w, i2c.write_data});
        end
        total++;
        if (i2c.dev_addr !== 7'h1D) begin
            bad++;
            $display("FAIL dev_addr: got %h expected 1d", i2c.dev_addr);
        end
        rst = 1'b0;
        step(10);
        total++;
        if (strobes.size() !== 0) begin
            bad++;
            $display("FAIL no_strobe_before_ready: got %0d strobes expected 0", strobes.size());
        end
        hold_ready = 1'b0;
    endtask

    task automatic test_config();
        bit ok;
        logic [16:0] exp_cfg [3];
        exp_cfg[0] = {8'h31, 1'b0, 8'h0B};
        exp_cfg[1] = {8'h2C, 1'b0, 8'h0A};
        exp_cfg[2] = {8'h2D, 1'b0, 8'h08};
        wait_strobes(3, 200, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL cfg_strobes: got %0d strobes expected 3", strobes.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if ({strobes[i].addr, strobes[i].rw, strobes[i].wd} !== exp_cfg[i]) begin
                    bad++;
                    $display("FAIL cfg_write%0d: got %h expected %h", i,
                             {strobes[i].addr, strobes[i].rw, strobes[i].wd}, exp_cfg[i]);
                end
            end
        end
        wait_cfg(100, ok);
        total++;
        if (!ok || cfg_rise_cyc !== last_fin_cyc + 1) begin
            bad++;
            $display("FAIL cfg_done_rise: got cycle %0d expected %0d", cfg_rise_cyc, last_fin_cyc + 1);
        end
    endtask

    task automatic test_read_burst();
        bit ok;
        wait_sv(1, 400, ok);
        total++;
        if (!ok || strobes.size() < 9) begin
            bad++;
            $display("FAIL first_sample: got sv=%0d strobes=%0d expected sv=1 strobes>=9", sv_cnt, strobes.size());
            return;
        end
        total++;
        if (strobes[3].cyc !== cfg_rise_cyc + 102) begin
            bad++;
            $display("FAIL first_tick_latency: got cycle %0d expected %0d", strobes[3].cyc, cfg_rise_cyc + 102);
        end
        for (int i = 0; i < 6; i++) begin
            total++;
            if ({strobes[3+i].addr, strobes[3+i].rw} !== {8'h32 + 8'(i), 1'b1}) begin
                bad++;
                $display("FAIL read_cmd%0d: got %h/%b expected %h/1", i,
                         strobes[3+i].addr, strobes[3+i].rw, 8'h32 + 8'(i));
            end
        end
        total++;
        if (last_sv_cyc !== strobes[3].cyc + 127) begin
            bad++;
            $display("FAIL sample_cycle: got %0d expected %0d", last_sv_cyc, strobes[3].cyc + 127);
        end
        total++;
        if ({accel_x, accel_y, accel_z} !== {16'h1234, 16'hFFFE, 16'h8000}) begin
            bad++;
            $display("FAIL sample_values: got %h expected 1234fffe8000", {accel_x, accel_y, accel_z});
        end
        step(1);
        total++;
        if (sample_valid !== 1'b0) begin
            bad++;
            $display("FAIL sample_valid_width: got %b expected 0", sample_valid);
        end
        step(30);
        total++;
        if (sv_cnt !== 1 || {accel_x, accel_y, accel_z} !== {16'h1234, 16'hFFFE, 16'h8000}) begin
            bad++;
            $display("FAIL sample_hold: got sv=%0d %h expected sv=1 1234fffe8000",
                     sv_cnt, {accel_x, accel_y, accel_z});
        end
    endtask

    task automatic test_ready_gating();
        int idx, n1, rel, sv0;
        bit ok;
        sv0 = sv_cnt;
        find_strobe(8'h33, strobes.size(), 300, idx);
        total++;
        if (idx < 0) begin
            bad++;
            $display("FAIL gate_find_0x33: got none expected strobe");
            return;
        end
        hold_ready = 1'b1;
        step(25);
        n1 = strobes.size();
        step(50);
        total++;
        if (strobes.size() !== n1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL gate_no_strobe: got strobes=%0d busy=%b expected %0d/0", strobes.size(), busy, n1);
        end
        hold_ready = 1'b0;
        rel = cyc;
        wait_strobes(n1 + 1, 10, ok);
        total++;
        if (!ok || strobes[n1].cyc !== rel + 1 || strobes[n1].addr !== 8'h34) begin
            bad++;
            $display("FAIL gate_release: got ok=%b cycle %0d addr %h expected cycle %0d addr 34",
                     ok, ok ? strobes[n1].cyc : -1, ok ? strobes[n1].addr : 8'h00, rel + 1);
        end
        wait_sv(sv0 + 1, 200, ok);
        total++;
        if (!ok || {accel_x, accel_y, accel_z} !== {16'h1234, 16'hFFFE, 16'h8000}) begin
            bad++;
            $display("FAIL gate_sample: got ok=%b %h expected 1234fffe8000", ok, {accel_x, accel_y, accel_z});
        end
    endtask

    task automatic test_overrun();
        int o0, svb, n0;
        bit ok;
        lat = 120;
        wait_sv(sv_cnt + 1, 1000, ok);
        mem[8'h32] = 8'h01; mem[8'h33] = 8'h00;
        mem[8'h34] = 8'h02; mem[8'h35] = 8'h00;
        mem[8'h36] = 8'hFF; mem[8'h37] = 8'h7F;
        o0 = ovr_cnt;
        wait_sv(sv_cnt + 1, 1200, ok);
        svb = last_sv_cyc;
        n0  = strobes.size();
        total++;
        if (!ok || {accel_x, accel_y, accel_z} !== {16'h0001, 16'h0002, 16'h7FFF}) begin
            bad++;
            $display("FAIL overrun_sample: got ok=%b %h expected 000100027fff", ok, {accel_x, accel_y, accel_z});
        end
        total++;
        if (ovr_cnt - o0 < 1) begin
            bad++;
            $display("FAIL overrun_pulse: got %0d pulses expected >=1", ovr_cnt - o0);
        end
        wait_strobes(n0 + 1, 5, ok);
        lat = 20;
        total++;
        if (!ok || strobes[n0].cyc !== svb + 1 || strobes[n0].addr !== 8'h32) begin
            bad++;
            $display("FAIL back_to_back: got ok=%b cycle %0d expected cycle %0d addr 32",
                     ok, ok ? strobes[n0].cyc : -1, svb + 1);
        end
    endtask

    task automatic test_timeout();
        int idx, s, t0, n0;
        bit ok;
        logic [47:0] axes;
        no_finish = 'h34;
        find_strobe(8'h34, strobes.size(), 1200, idx);
        total++;
        if (idx < 0) begin
            bad++;
            $display("FAIL timeout_find_0x34: got none expected strobe");
            no_finish = -1;
            return;
        end
        s    = strobes[idx].cyc;
        axes = {accel_x, accel_y, accel_z};
        t0   = to_cnt;
        for (int k = 0; k < 700 && to_cnt == t0; k++) step(1);
        n0 = strobes.size();
        total++;
        if (to_cnt !== t0 + 1 || last_to_cyc !== s + 501) begin
            bad++;
            $display("FAIL timeout_cycle: got count %0d cycle %0d expected count %0d cycle %0d",
                     to_cnt - t0, last_to_cyc, 1, s + 501);
        end
        total++;
        if (cfg_done !== 1'b0) begin
            bad++;
            $display("FAIL timeout_cfg_done: got %b expected 0", cfg_done);
        end
        total++;
        if (n0 < 1 || {strobes[n0-1].addr, strobes[n0-1].rw, strobes[n0-1].wd} !== {8'h31, 1'b0, 8'h0B}) begin
            bad++;
            $display("FAIL timeout_restart: got %h expected 31 0 0b",
                     n0 < 1 ? 17'h0 : {strobes[n0-1].addr, strobes[n0-1].rw, strobes[n0-1].wd});
        end
        total++;
        if ({accel_x, accel_y, accel_z} !== axes) begin
            bad++;
            $display("FAIL timeout_axes_hold: got %h expected %h", {accel_x, accel_y, accel_z}, axes);
        end
        no_finish = -1;
        wait_cfg(200, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL timeout_reconfig: got cfg_done=%b expected 1", cfg_done);
        end
    endtask

    task automatic test_mid_reset();
        int idx, n0;
        bit ok;
        find_strobe(8'h33, strobes.size(), 400, idx);
        total++;
        if (idx < 0) begin
            bad++;
            $display("FAIL midrst_find_0x33: got none expected strobe");
            return;
        end
        step(5);
        hold_ready = 1'b1;
        rst = 1'b1;
        step(1);
        total++;
        if ({accel_x, accel_y, accel_z, sample_valid, cfg_done, busy, timeout_err, sample_overrun,
             i2c.start_i2c_comms, i2c.reg_addr, i2c.r_w, i2c.write_data} !== 71'h0) begin
            bad++;
            $display("FAIL midrst_outputs: got %h/%b/%h expected all zero",
                     {accel_x, accel_y, accel_z},
                     {sample_valid, cfg_done, busy, timeout_err, sample_overrun, i2c.start_i2c_comms},
                     {i2c.reg_addr, i2c.r_w, i2c.write_data});
        end
        rst = 1'b0;
        hold_ready = 1'b0;
        n0 = strobes.size();
        wait_strobes(n0 + 1, 10, ok);
        total++;
        if (!ok || {strobes[n0].addr, strobes[n0].rw, strobes[n0].wd} !== {8'h31, 1'b0, 8'h0B}) begin
            bad++;
            $display("FAIL midrst_first_cmd: got ok=%b %h expected 31 0 0b", ok,
                     ok ? {strobes[n0].addr, strobes[n0].rw, strobes[n0].wd} : 17'h0);
        end
    endtask

    initial begin
        foreach (mem[i]) mem[i] = 8'h00;
        mem[8'h32] = 8'h34; mem[8'h33] = 8'h12;
        mem[8'h34] = 8'hFE; mem[8'h35] = 8'hFF;
        mem[8'h36] = 8'h00; mem[8'h37] = 8'h80;

        test_reset();
        test_config();
        test_read_burst();
        test_ready_gating();
        test_overrun();
        test_timeout();
        test_mid_reset();

        total++;
        if (rdy_err !== 0) begin
            bad++;
            $display("FAIL strobe_without_ready: got %0d expected 0", rdy_err);
        end
        total++;
        if (stab_err !== 0) begin
            bad++;
            $display("FAIL cmd_stability: got %0d unstable cycles expected 0", stab_err);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/accel_poll_sequencer.md
Name: accel_poll_sequencer

Overview:
- Sequences the existing i2c_controller to configure the on-board G-sensor and then poll it.
- After reset it writes a fixed configuration table. It then reads the six X/Y/Z data registers at a fixed sample rate.
- It publishes signed 16-bit axis values with a one-cycle valid strobe to the 7-segment display path.
- It is the only master of the i2c_controller command interface.

Parameters:
- SYS_CLK_SPEED, 50000000: system clock frequency in Hz.
- SAMPLE_RATE_HZ, 100: poll rate. Sample period in cycles: PERIOD = SYS_CLK_SPEED/SAMPLE_RATE_HZ, integer division, must be ≥ 2.
- DEV_ADDR, 7'h1D: sensor I2C device address, driven constant on dev_addr.
- TIMEOUT_CYCLES, 2000000: maximum wait from start issue to i2c_comms_finished before abort.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- i2c_ready  in  1  from i2c_controller ready; a command may be issued only while high
- i2c_comms_finished  in  1  one-cycle pulse from i2c_controller on transaction completion
- i2c_read_data  in  8  READ_DATA from i2c_controller; valid in the cycle of i2c_comms_finished
- start_i2c_comms  out  1  one-cycle command strobe
- dev_addr  out  7  constant DEV_ADDR
- reg_addr  out  8  register address; held stable from strobe until finished
- r_w  out  1  1 = read, 0 = write; held like reg_addr
- write_data  out  8  write byte; held like reg_addr
- accel_x, accel_y, accel_z  out  16 each  signed samples, {DATAn1, DATAn0}
- sample_valid  out  1  one-cycle pulse; all three axes updated in the same cycle
- cfg_done  out  1  level; high once the configuration table has completed
- busy  out  1  high while a transaction is outstanding
- timeout_err  out  1  one-cycle pulse on transaction timeout
- sample_overrun  out  1  one-cycle pulse when a sample tick arrives while a tick is already pending

Behaviour:
- Reset values: every output 0 except dev_addr (constant). State = CFG_ISSUE, table index 0, timers 0, pending tick cleared.
- Configuration table, in this order:
  - reg 0x31 ← 0x0B (DATA_FORMAT: full resolution, ±16 g)
  - reg 0x2C ← 0x0A (BW_RATE: 100 Hz)
  - reg 0x2D ← 0x08 (POWER_CTL: measure)
- Read table: 0x32, 0x33, 0x34, 0x35, 0x36, 0x37, stored as X0, X1, Y0, Y1, Z0, Z1. Each is a single-byte read transaction.
- States:
  - CFG_ISSUE: when i2c_ready=1, drive reg_addr/write_data/r_w=0 and pulse start_i2c_comms for exactly 1 cycle. Go to CFG_WAIT.
  - CFG_WAIT: on i2c_comms_finished, increment the index. At index 3, set cfg_done=1, clear the index and go to IDLE; otherwise go to CFG_ISSUE.
  - IDLE: when a tick is pending, clear it and go to RD_ISSUE with index 0.
  - RD_ISSUE: same strobe rule as CFG_ISSUE, with r_w=1.
  - RD_WAIT: on i2c_comms_finished, latch i2c_read_data into a byte buffer[index]. After index 5 go to PUBLISH; otherwise go to RD_ISSUE.
  - PUBLISH: load accel_x/y/z from the buffer, pulse sample_valid, go to IDLE. Outputs change only here; partial bursts never reach the outputs.
- Strobe latency: start_i2c_comms asserts in the first cycle in which the state is *_ISSUE and i2c_ready=1. It never asserts while i2c_ready=0.
- busy: 1 from the strobe cycle through the cycle of i2c_comms_finished inclusive.
- Sample timer:
  - Counts 0..PERIOD-1 and wraps; wrap generates a tick. Free-running only while cfg_done=1.
  - The first tick comes PERIOD cycles after cfg_done rises.
  - The pending tick is one-deep. A tick while pending=1 pulses sample_overrun and is otherwise dropped.
  - A tick in the same cycle that IDLE consumes the pending tick sets pending again (no overrun).
- Timeout:
  - The wait counter clears on every strobe and counts in *_WAIT.
  - Reaching TIMEOUT_CYCLES pulses timeout_err, clears cfg_done, pending and the index, and returns to CFG_ISSUE. Axis outputs hold their last values.
- i2c_comms_finished outside *_WAIT is ignored.
- rst asserted mid-transaction returns every register to its reset value on the next edge. No command is issued during reset.

Decomposition:
- Shared package accel_pkg:
  - typedef enum seq_state_e {CFG_ISSUE, CFG_WAIT, IDLE, RD_ISSUE, RD_WAIT, PUBLISH}
  - localparam arrays CFG_REG/CFG_DATA [3] and RD_REG [6]
  - localparams for register addresses 0x2C, 0x2D, 0x31, 0x32
- One sub-module, sample_tick_gen: parameter PERIOD; inputs clk, rst, enable; output one-cycle tick. It contains the wrap counter only.

Test Plan:
- Bench setup: SYS_CLK_SPEED=1000, SAMPLE_RATE_HZ=10 (PERIOD=100), TIMEOUT_CYCLES=500. The bench models the i2c_controller: ready, then finished 20 cycles after each strobe.
- Reset/config: release rst → three write strobes, in order (0x31, 0x0B), (0x2C, 0x0A), (0x2D, 0x08), all with r_w=0; cfg_done rises 1 cycle after the third finished; no strobe before ready.
- Read burst: the model returns 0x34, 0x12, 0xFE, 0xFF, 0x00, 0x80 for 0x32..0x37 → a single sample_valid pulse with accel_x=0x1234, accel_y=0xFFFE (-2), accel_z=0x8000; outputs stable until the next PUBLISH.
- Ready gating: hold i2c_ready=0 for 50 cycles in RD_ISSUE → no strobe; strobe in the first cycle ready=1; reg_addr stable until finished.
- Overrun: finished latency of 120 cycles per read → pending set during the burst; the second tick pulses sample_overrun; bursts continue back-to-back with no lost data bytes.
- Timeout: never return finished on the 0x34 read → timeout_err pulse at wait count 500; cfg_done=0; the next strobe is the 0x31 write; accel outputs keep their previous values.
- Mid-op reset: assert rst for 1 cycle during RD_WAIT → all outputs 0, and the next command is the 0x31 config write.
